fp16_addsub_arbiter: RTL

//  Shares one combinational IEEE-754 half-precision add/sub unit between two requesters.
//  - Round-robin arbitration; the granted operand set is registered and driven onto the unit.
//  - Result is sampled after LAT cycles and returned on a valid/ready response channel tagged to the winner.
//  - Sits between the requester datapaths and the fp16 add/sub instance (C,D,ch -> A).

---
 rtl/fp16_addsub_arbiter_if.sv | 51 +++++
 rtl/fp16_addsub_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fp16_addsub_arbiter_if.sv
// fp16_addsub_arbiter_if
//   Bundles the requester, response and add/sub-unit signals of
//   fp16_addsub_arbiter. Clock and reset stay plain ports on the module.
//   slave  : arbiter view (consumes requests, drives responses and the unit)
//   master : environment view (requesters, response sinks and the add/sub unit)
//   Signals:
//     req0/1_valid, req0/1_ready    request handshake per requester
//     req0/1_c, req0/1_d, req0/1_ch fp16 operands and op select (1 = C-D)
//     rsp0/1_valid, rsp0/1_ready    response handshake per requester
//     rsp_a                         fp16 result shared by both response channels
//     add_c, add_d, add_ch          operands driven onto the add/sub unit
//     add_a                         result returned by the add/sub unit
//     busy                          operation in flight or response pending
interface fp16_addsub_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_c;
  logic [15:0] req0_d;
  logic        req0_ch;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_c;
  logic [15:0] req1_d;
  logic        req1_ch;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [15:0] rsp_a;
  logic [15:0] add_c;
  logic [15:0] add_d;
  logic        add_ch;
  logic [15:0] add_a;
  logic        busy;

  modport slave (
    input  req0_valid, req0_c, req0_d, req0_ch,
    input  req1_valid, req1_c, req1_d, req1_ch,
    input  rsp0_ready, rsp1_ready, add_a,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_a,
    output add_c, add_d, add_ch, busy
  );

  modport master (
    output req0_valid, req0_c, req0_d, req0_ch,
    output req1_valid, req1_c, req1_d, req1_ch,
    output rsp0_ready, rsp1_ready, add_a,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_a,
    input  add_c, add_d, add_ch, busy
  );
endinterface

// File: rtl/fp16_addsub_arbiter.sv
// fp16_addsub_arbiter
//   Shares one combinational fp16 add/sub unit between two requesters.
//   A round-robin winner's operands are registered onto the unit, the unit
//   result is sampled after LAT cycles and returned on the winner's response
//   channel. No arithmetic is done here; fp16 bits pass straight through.
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous active-high reset (aborts any operation)
//     bus       fp16_addsub_arbiter_if.slave (requests, responses, unit)
//     gnt0_cnt  saturating grant count, requester 0 (GRANT_CNT_EN only)
//     gnt1_cnt  saturating grant count, requester 1 (GRANT_CNT_EN only)
//   Parameters:
//     LAT    cycles operands are held on the unit before sampling (1..15)
//     CNT_W  grant counter width (GRANT_CNT_EN only)
//   Optional feature macro: GRANT_CNT_EN adds the grant counters.
module fp16_addsub_arbiter #(
  parameter int unsigned LAT   = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fp16_addsub_arbiter_if.slave bus
`ifdef GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0]     gnt0_cnt,
  output logic [CNT_W-1:0]     gnt1_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [3:0] LAT_CNT = 4'(LAT);

  logic [1:0] state;
  logic       last;      // requester served most recently
  logic       tag;       // requester owning the operation in flight
  logic [3:0] cnt;       // remaining hold cycles before sampling add_a
  logic       grant0;
  logic       grant1;
  logic       take0;
  logic       take1;
  logic       rsp_take;

  // Round-robin choice: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0 = last;
      grant1 = ~last;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end

  assign take0          = (state == ST_IDLE) & grant0;
  assign take1          = (state == ST_IDLE) & grant1;
  assign bus.req0_ready = take0;
  assign bus.req1_ready = take1;
  // Only the tagged channel's ready can complete the response
  assign rsp_take       = tag ? bus.rsp1_ready : bus.rsp0_ready;
  assign bus.rsp0_valid = (state == ST_RESP) & ~tag;
  assign bus.rsp1_valid = (state == ST_RESP) & tag;
  assign bus.busy       = (state != ST_IDLE);

  // Control FSM plus operand and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last       <= 1'b1;
      tag        <= 1'b0;
      cnt        <= 4'd0;
      bus.add_c  <= 16'h0000;
      bus.add_d  <= 16'h0000;
      bus.add_ch <= 1'b0;
      bus.rsp_a  <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take0 || take1) begin
            bus.add_c  <= take1 ? bus.req1_c  : bus.req0_c;
            bus.add_d  <= take1 ? bus.req1_d  : bus.req0_d;
            bus.add_ch <= take1 ? bus.req1_ch : bus.req0_ch;
            tag        <= take1;
            cnt        <= LAT_CNT;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 4'd1;
          // Operands have now been on the unit for LAT cycles
          if (cnt == 4'd1) begin
            bus.rsp_a <= bus.add_a;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_take) begin
            last  <= tag;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GRANT_CNT_EN
  // Saturating per-requester request-handshake counters
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_cnt <= '0;
      gnt1_cnt <= '0;
    end else begin
      if (take0 && (gnt0_cnt != {CNT_W{1'b1}})) begin
        gnt0_cnt <= gnt0_cnt + CNT_W'(1);
      end
      if (take1 && (gnt1_cnt != {CNT_W{1'b1}})) begin
        gnt1_cnt <= gnt1_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
